sensor_threshold_conditioner: RTL and testbench
===============================================

SENSOR_THRESHOLD_CONDITIONER -- requirements
Module: sensor_threshold_conditioner

Interface
REQ-001 SHALL have parameter TH_HI, default 8'd160, meaning rising threshold; a sample >= TH_HI qualifies high.
REQ-002 SHALL have parameter TH_LO, default 8'd96, meaning falling threshold; a sample < TH_LO qualifies low.
REQ-003 SHALL have parameter PERSIST, default 4, meaning the number of consecutive qualifying samples required to toggle an output (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sync_clr, input, 1 bit: synchronous clear of both channels.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample_a and sample_b are valid this cycle.
REQ-008 SHALL have ports sample_a and sample_b, input, 8 bits each: unsigned sensor readings (inducer channels A and B).
REQ-009 SHALL have ports in_A and in_B, output, 1 bit each: registered, conditioned logic levels that drive the downstream gate inputs of the same names.
REQ-010 SHALL have port changed, output, 1 bit: a one-cycle pulse in the cycle after in_A or in_B toggles.

Function
REQ-011 SHALL run two identical, independent channels (A, B); each channel has states LOW, RISE_PEND, HIGH and FALL_PEND, plus a 4-bit count.
REQ-012 SHALL hold state and count unchanged in any cycle where sample_valid=0.
REQ-013 SHALL update as follows on a valid sample in LOW: if sample >= TH_HI, count=1 and go to RISE_PEND, or go directly to HIGH if PERSIST=1; otherwise stay in LOW with count=0.
REQ-014 SHALL update as follows on a valid sample in RISE_PEND: if sample >= TH_HI, count++, and go to HIGH when count reaches PERSIST; otherwise go to LOW with count=0.
REQ-015 SHALL apply REQ-013/REQ-014 symmetrically for HIGH and FALL_PEND, using sample < TH_LO as the qualifying condition.
REQ-016 SHALL set count=0 on every entry to LOW or HIGH; count never exceeds PERSIST and never wraps.
REQ-017 SHALL treat samples with TH_LO <= sample < TH_HI as non-qualifying in every state (hysteresis band).
REQ-018 SHALL register outputs: in_X=1 iff the channel state is HIGH or FALL_PEND, so latency is one clock after the PERSIST-th qualifying sample.
REQ-019 SHALL assert changed for exactly one cycle in the cycle after the in_A or in_B register changes value; when both toggle on the same edge, the result is a single one-cycle pulse.
REQ-020 SHALL give sync_clr priority over sample_valid: at the next edge both channels go to LOW, count=0, in_A=in_B=0, and changed=0.
REQ-021 SHALL raise a simulation-time error at time 0 if TH_LO >= TH_HI or PERSIST is outside 1..15.

Reset
REQ-022 SHALL, while rst_n=0, immediately force both channels to LOW, count=0, in_A=0, in_B=0 and changed=0, independent of clk.
REQ-023 SHALL abandon any pending qualification when reset is asserted mid-sequence; after release, qualification restarts from count 0.
REQ-024 SHALL release reset synchronously to the design: the first state update occurs on the first clk rising edge with rst_n=1.

Configuration
REQ-025 SHALL, when macro SENSOR_COND_TOGGLE_CNT_EN is defined, add outputs toggles_a and toggles_b (8 bits each): counters that increment on every in_X transition and saturate at 255; they are cleared by rst_n and by sync_clr.
REQ-026 SHALL, when SENSOR_COND_TOGGLE_CNT_EN is not defined, omit those ports and counters entirely, with all other behaviour identical.

Verification
REQ-027 SHALL cover: defaults, sample_a=200 valid for 4 consecutive cycles -> in_A=1 on the edge after the 4th sample, changed pulses 1 cycle later, in_B stays 0.
REQ-028 SHALL cover: sample_a = 200, 200, 200, 120, 200, 200, 200, 200 -> in_A rises only after the 8th sample (the 120 resets the count).
REQ-029 SHALL cover: in_A=1, then sample_a=100 for 10 samples -> in_A stays 1 (hysteresis band); then 50 for 4 samples -> in_A=0.
REQ-030 SHALL cover: sample_valid gaps of 3 idle cycles between each of four 200 samples -> in_A rises after the 4th valid sample.
REQ-031 SHALL cover: rst_n pulled low after the 3rd of 4 qualifying samples -> outputs 0 immediately; the next 3 samples of 200 give no rise, and the 4th gives a rise.
REQ-032 SHALL cover: sync_clr=1 together with the 4th qualifying sample -> in_A stays 0; with PERSIST=1 and SENSOR_COND_TOGGLE_CNT_EN defined, 300 alternating 200/50 samples -> toggles_a=255.

Source files
------------

// File: rtl/sensor_threshold_conditioner.sv
// rtl/sensor_threshold_conditioner.sv - two-channel hysteresis/persistence conditioner for sensor thresholds
//
// Purpose:
//   Turns two 8-bit sensor streams (channels A and B) into clean logic levels.
//   A channel switches high after PERSIST consecutive valid samples >= TH_HI.
//   It switches low after PERSIST consecutive valid samples < TH_LO.
//   Samples inside the band [TH_LO, TH_HI) qualify in neither direction.
//
// Ports:
//   clk           - single clock, all state updates on the rising edge
//   rst_n         - asynchronous active-low reset
//   sync_clr      - synchronous clear of both channels, wins over sample_valid
//   sample_valid  - sample_a/sample_b carry a valid reading this cycle
//   sample_a/b    - unsigned 8-bit sensor readings
//   in_A/in_B     - registered conditioned levels (HIGH or FALL_PEND -> 1)
//   changed       - one-cycle pulse in the cycle after in_A or in_B toggles
//   toggles_a/b   - saturating transition counters (only with the macro below)
//
// Optional feature:
//   SENSOR_COND_TOGGLE_CNT_EN - adds toggles_a/toggles_b outputs and counters.

module sensor_threshold_conditioner #(
  parameter logic [7:0]  TH_HI   = 8'd160,
  parameter logic [7:0]  TH_LO   = 8'd96,
  parameter int unsigned PERSIST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_clr,
  input  logic       sample_valid,
  input  logic [7:0] sample_a,
  input  logic [7:0] sample_b,
  output logic       in_A,
  output logic       in_B,
`ifdef SENSOR_COND_TOGGLE_CNT_EN
  output logic [7:0] toggles_a,
  output logic [7:0] toggles_b,
`endif
  output logic       changed
);

  // Illegal configurations are rejected while the design is elaborated.
  if (TH_LO >= TH_HI) begin : g_bad_thresholds
    $error("sensor_threshold_conditioner: TH_LO must be below TH_HI");
  end
  if ((PERSIST < 1) || (PERSIST > 15)) begin : g_bad_persist
    $error("sensor_threshold_conditioner: PERSIST must be in 1..15");
  end

  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_e;

  typedef struct packed {
    state_e     st;
    logic [3:0] cnt;
  } chan_t;

  // One channel's next state. Both channels share this so they stay identical.
  // The count only ever counts up to PERSIST and is zeroed on entry to a stable
  // state, so it cannot wrap.
  function automatic chan_t chan_next(input chan_t cur, input logic valid,
                                      input logic hi_qual, input logic lo_qual);
    chan_t nxt;
    nxt = cur;
    if (valid) begin
      case (cur.st)
        ST_LOW: begin
          if (hi_qual) begin
            if (PERSIST_C == 4'd1) begin
              nxt.st  = ST_HIGH;
              nxt.cnt = 4'd0;
            end else begin
              nxt.st  = ST_RISE_PEND;
              nxt.cnt = 4'd1;
            end
          end else begin
            nxt.cnt = 4'd0;
          end
        end
        ST_RISE_PEND: begin
          if (hi_qual) begin
            if ((cur.cnt + 4'd1) == PERSIST_C) begin
              nxt.st  = ST_HIGH;
              nxt.cnt = 4'd0;
            end else begin
              nxt.cnt = cur.cnt + 4'd1;
            end
          end else begin
            nxt.st  = ST_LOW;
            nxt.cnt = 4'd0;
          end
        end
        ST_HIGH: begin
          if (lo_qual) begin
            if (PERSIST_C == 4'd1) begin
              nxt.st  = ST_LOW;
              nxt.cnt = 4'd0;
            end else begin
              nxt.st  = ST_FALL_PEND;
              nxt.cnt = 4'd1;
            end
          end else begin
            nxt.cnt = 4'd0;
          end
        end
        ST_FALL_PEND: begin
          if (lo_qual) begin
            if ((cur.cnt + 4'd1) == PERSIST_C) begin
              nxt.st  = ST_LOW;
              nxt.cnt = 4'd0;
            end else begin
              nxt.cnt = cur.cnt + 4'd1;
            end
          end else begin
            nxt.st  = ST_HIGH;
            nxt.cnt = 4'd0;
          end
        end
        default: begin
          nxt.st  = ST_LOW;
          nxt.cnt = 4'd0;
        end
      endcase
    end
    return nxt;
  endfunction

  function automatic logic level_of(input state_e st);
    return (st == ST_HIGH) || (st == ST_FALL_PEND);
  endfunction

  chan_t ch_a_q, ch_a_d;
  chan_t ch_b_q, ch_b_d;
  logic  in_a_q, in_a_d;
  logic  in_b_q, in_b_d;
  // Copies of the level registers one cycle later; changed compares against
  // these so it lands in the cycle after the level register moved.
  logic  in_a_prev_q, in_b_prev_q;
  logic  changed_q, changed_d;

  always_comb begin
    ch_a_d    = chan_next(ch_a_q, sample_valid, sample_a >= TH_HI, sample_a < TH_LO);
    ch_b_d    = chan_next(ch_b_q, sample_valid, sample_b >= TH_HI, sample_b < TH_LO);
    in_a_d    = level_of(ch_a_d.st);
    in_b_d    = level_of(ch_b_d.st);
    // A simultaneous toggle on both channels still gives one pulse.
    changed_d = (in_a_q != in_a_prev_q) || (in_b_q != in_b_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_a_q      <= '{st: ST_LOW, cnt: 4'd0};
      ch_b_q      <= '{st: ST_LOW, cnt: 4'd0};
      in_a_q      <= 1'b0;
      in_b_q      <= 1'b0;
      in_a_prev_q <= 1'b0;
      in_b_prev_q <= 1'b0;
      changed_q   <= 1'b0;
    end else if (sync_clr) begin
      // The history registers are cleared too, so a clear from a high level
      // does not produce a changed pulse afterwards.
      ch_a_q      <= '{st: ST_LOW, cnt: 4'd0};
      ch_b_q      <= '{st: ST_LOW, cnt: 4'd0};
      in_a_q      <= 1'b0;
      in_b_q      <= 1'b0;
      in_a_prev_q <= 1'b0;
      in_b_prev_q <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      ch_a_q      <= ch_a_d;
      ch_b_q      <= ch_b_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      in_a_prev_q <= in_a_q;
      in_b_prev_q <= in_b_q;
      changed_q   <= changed_d;
    end
  end

  assign in_A    = in_a_q;
  assign in_B    = in_b_q;
  assign changed = changed_q;

`ifdef SENSOR_COND_TOGGLE_CNT_EN
  logic [7:0] tog_a_q, tog_a_d;
  logic [7:0] tog_b_q, tog_b_d;

  // Count on the edge where the level register itself changes; hold at 255.
  always_comb begin
    tog_a_d = tog_a_q;
    tog_b_d = tog_b_q;
    if ((in_a_d != in_a_q) && (tog_a_q != 8'hFF)) begin
      tog_a_d = tog_a_q + 8'd1;
    end
    if ((in_b_d != in_b_q) && (tog_b_q != 8'hFF)) begin
      tog_b_d = tog_b_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_a_q <= 8'd0;
      tog_b_q <= 8'd0;
    end else if (sync_clr) begin
      tog_a_q <= 8'd0;
      tog_b_q <= 8'd0;
    end else begin
      tog_a_q <= tog_a_d;
      tog_b_q <= tog_b_d;
    end
  end

  assign toggles_a = tog_a_q;
  assign toggles_b = tog_b_q;
`endif

endmodule

// File: tb/tb_sensor_threshold_conditioner.sv
// tb/tb_sensor_threshold_conditioner.sv - directed self-checking bench for sensor_threshold_conditioner

module tb_sensor_threshold_conditioner;

  logic       clk;
  logic       rst_n;
  logic       sync_clr;
  logic       sample_valid;
  logic [7:0] sample_a;
  logic [7:0] sample_b;
  logic       in_A;
  logic       in_B;
  logic       changed;

  int total;
  int bad;

`ifdef SENSOR_COND_TOGGLE_CNT_EN
  logic [7:0] toggles_a, toggles_b;
  logic       p1_valid;
  logic [7:0] p1_a, p1_b;
  logic       p1_in_a, p1_in_b, p1_changed;
  logic [7:0] p1_tog_a, p1_tog_b;
`endif

  sensor_threshold_conditioner u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_clr     (sync_clr),
    .sample_valid (sample_valid),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .in_A         (in_A),
    .in_B         (in_B),
`ifdef SENSOR_COND_TOGGLE_CNT_EN
    .toggles_a    (toggles_a),
    .toggles_b    (toggles_b),
`endif
    .changed      (changed)
  );

`ifdef SENSOR_COND_TOGGLE_CNT_EN
  sensor_threshold_conditioner #(.PERSIST(1)) u_dut_p1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_clr     (sync_clr),
    .sample_valid (p1_valid),
    .sample_a     (p1_a),
    .sample_b     (p1_b),
    .in_A         (p1_in_a),
    .in_B         (p1_in_b),
    .toggles_a    (p1_tog_a),
    .toggles_b    (p1_tog_b),
    .changed      (p1_changed)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs; returns #1 after the edge that consumed them.
  task automatic put(input logic v, input logic [7:0] a, input logic [7:0] b);
    sample_valid = v;
    sample_a     = a;
    sample_b     = b;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 8'd0, 8'd0);
  endtask

  task automatic drop_a();
    for (int i = 0; i < 4; i++) put(1'b1, 8'd50, 8'd0);
    check_eq("drop_a", in_A, 1'b0);
    idle(2);
  endtask

  logic [7:0] seq2 [8];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sync_clr = 1'b0;
    sample_valid = 1'b0;
    sample_a = 8'd0;
    sample_b = 8'd0;
`ifdef SENSOR_COND_TOGGLE_CNT_EN
    p1_valid = 1'b0;
    p1_a = 8'd0;
    p1_b = 8'd0;
`endif
    seq2 = '{8'd200, 8'd200, 8'd200, 8'd120, 8'd200, 8'd200, 8'd200, 8'd200};

    #3;
    check_eq("rst_in_a", in_A, 1'b0);
    check_eq("rst_in_b", in_B, 1'b0);
    check_eq("rst_changed", changed, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // four qualifying samples on A
    for (int i = 0; i < 3; i++) put(1'b1, 8'd200, 8'd0);
    check_eq("t1_pre", in_A, 1'b0);
    put(1'b1, 8'd200, 8'd0);
    check_eq("t1_rise", in_A, 1'b1);
    check_eq("t1_b_low", in_B, 1'b0);
    check_eq("t1_chg_same", changed, 1'b0);
    idle(1);
    check_eq("t1_chg_pulse", changed, 1'b1);
    idle(1);
    check_eq("t1_chg_end", changed, 1'b0);
    check_eq("t1_hold", in_A, 1'b1);
    for (int i = 0; i < 3; i++) put(1'b1, 8'd50, 8'd0);
    check_eq("t1_fall_pre", in_A, 1'b1);
    put(1'b1, 8'd50, 8'd0);
    check_eq("t1_fall", in_A, 1'b0);
    idle(1);
    check_eq("t1_fall_chg", changed, 1'b1);
    idle(1);

    // a band sample in the middle restarts the count
    for (int i = 0; i < 7; i++) put(1'b1, seq2[i], 8'd0);
    check_eq("t2_seven", in_A, 1'b0);
    put(1'b1, seq2[7], 8'd0);
    check_eq("t2_eighth", in_A, 1'b1);
    idle(2);

    // hysteresis band holds a high level
    for (int i = 0; i < 10; i++) put(1'b1, 8'd100, 8'd0);
    check_eq("t3_band", in_A, 1'b1);
    check_eq("t3_band_chg", changed, 1'b0);
    for (int i = 0; i < 3; i++) put(1'b1, 8'd50, 8'd0);
    check_eq("t3_low3", in_A, 1'b1);
    put(1'b1, 8'd50, 8'd0);
    check_eq("t3_low4", in_A, 1'b0);
    idle(2);

    // idle gaps between valid samples keep the count
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 8'd200, 8'd0);
      idle(3);
    end
    check_eq("t4_gap_pre", in_A, 1'b0);
    put(1'b1, 8'd200, 8'd0);
    check_eq("t4_gap_rise", in_A, 1'b1);
    idle(2);
    drop_a();

    // asynchronous reset mid-sequence
    for (int i = 0; i < 4; i++) put(1'b1, 8'd0, 8'd200);
    check_eq("t5_b_high", in_B, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) put(1'b1, 8'd200, 8'd200);
    check_eq("t5_a_pend", in_A, 1'b0);
    check_eq("t5_b_still", in_B, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_b", in_B, 1'b0);
    check_eq("t5_async_a", in_A, 1'b0);
    check_eq("t5_async_chg", changed, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) put(1'b1, 8'd200, 8'd0);
    check_eq("t5_restart3", in_A, 1'b0);
    check_eq("t5_no_chg", changed, 1'b0);
    put(1'b1, 8'd200, 8'd0);
    check_eq("t5_restart4", in_A, 1'b1);
    idle(2);
    drop_a();

    // sync_clr beats the 4th qualifying sample
    for (int i = 0; i < 3; i++) put(1'b1, 8'd200, 8'd0);
    sync_clr = 1'b1;
    put(1'b1, 8'd200, 8'd0);
    sync_clr = 1'b0;
    check_eq("t6_clr_a", in_A, 1'b0);
    for (int i = 0; i < 3; i++) put(1'b1, 8'd200, 8'd0);
    check_eq("t6_after3", in_A, 1'b0);
    put(1'b1, 8'd200, 8'd0);
    check_eq("t6_after4", in_A, 1'b1);
    idle(2);
    sync_clr = 1'b1;
    put(1'b0, 8'd0, 8'd0);
    sync_clr = 1'b0;
    check_eq("t6_clr_high", in_A, 1'b0);
    check_eq("t6_clr_chg", changed, 1'b0);
    idle(1);

    // both channels toggle on one edge -> one pulse
    for (int i = 0; i < 4; i++) put(1'b1, 8'd200, 8'd200);
    check_eq("t7_a", in_A, 1'b1);
    check_eq("t7_b", in_B, 1'b1);
    idle(1);
    check_eq("t7_pulse", changed, 1'b1);
    idle(1);
    check_eq("t7_single", changed, 1'b0);
    for (int i = 0; i < 4; i++) put(1'b1, 8'd50, 8'd50);
    check_eq("t7_both_low", {in_A, in_B}, 2'b00);
    idle(2);

    // threshold boundaries on B
    for (int i = 0; i < 4; i++) put(1'b1, 8'd0, 8'd159);
    check_eq("t8_159", in_B, 1'b0);
    for (int i = 0; i < 4; i++) put(1'b1, 8'd0, 8'd160);
    check_eq("t8_160", in_B, 1'b1);
    for (int i = 0; i < 4; i++) put(1'b1, 8'd0, 8'd96);
    check_eq("t8_96", in_B, 1'b1);
    for (int i = 0; i < 4; i++) put(1'b1, 8'd0, 8'd95);
    check_eq("t8_95", in_B, 1'b0);
    idle(2);

`ifdef SENSOR_COND_TOGGLE_CNT_EN
    sync_clr = 1'b1;
    put(1'b0, 8'd0, 8'd0);
    sync_clr = 1'b0;
    check_eq("t9_clr_tog", p1_tog_a, 8'd0);
    for (int i = 0; i < 300; i++) begin
      p1_valid = 1'b1;
      p1_a = (i % 2 == 0) ? 8'd200 : 8'd50;
      @(posedge clk);
      #1;
      p1_valid = 1'b0;
      if (i == 9) check_eq("t9_tog10", p1_tog_a, 8'd10);
    end
    check_eq("t9_tog_sat", p1_tog_a, 8'd255);
    check_eq("t9_tog_b", p1_tog_b, 8'd0);
    check_eq("t9_main_tog", toggles_a, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
